// File: rtl/error_mod_map_pkg.sv
// Shared JPEG-LS datapath widths for the residual modulo-reduction stage.
package error_mod_map_pkg;

    localparam int unsigned residual_length    = 9;
    localparam int unsigned modresidual_length = 8;
    localparam int unsigned RANGE              = 1 << modresidual_length;

endpackage

// File: rtl/error_mod_map_err_map_comb.sv
// Combinational modulo reduction and MErrval mapping; shared with the decoder's inverse path.
module err_map_comb
    import error_mod_map_pkg::*;
#(
    parameter int unsigned MODRESIDUAL_LENGTH = modresidual_length
) (
    input  logic [MODRESIDUAL_LENGTH-1:0] residual,
    output logic [MODRESIDUAL_LENGTH-1:0] reduced,
    output logic [MODRESIDUAL_LENGTH-1:0] mapped
);

    // Modulo-RANGE reduction into [-RANGE/2, RANGE/2-1] is the low-bit slice read as signed.
    always_comb begin
        reduced = residual;
        mapped  = {reduced[MODRESIDUAL_LENGTH-2:0], 1'b0}
                ^ {MODRESIDUAL_LENGTH{reduced[MODRESIDUAL_LENGTH-1]}};
    end

endmodule

// File: rtl/error_mod_map.sv
// Registered residual reduction/mapping stage between the residual subtractor and Golomb coder.
module error_mod_map
    import error_mod_map_pkg::*;
#(
    parameter int unsigned RESIDUAL_LENGTH    = residual_length,
    parameter int unsigned MODRESIDUAL_LENGTH = modresidual_length
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [RESIDUAL_LENGTH-1:0]    errValue,
    output logic                          out_valid,
    output logic [MODRESIDUAL_LENGTH-1:0] errorModulo,
    output logic [MODRESIDUAL_LENGTH-1:0] errReduced
);

    logic [MODRESIDUAL_LENGTH-1:0] reduced;
    logic [MODRESIDUAL_LENGTH-1:0] mapped;
    logic                          unused_msb;

    // The input sign bit carries no information once reduced modulo RANGE.
    assign unused_msb = errValue[RESIDUAL_LENGTH-1];

    err_map_comb #(
        .MODRESIDUAL_LENGTH(MODRESIDUAL_LENGTH)
    ) u_err_map_comb (
        .residual(errValue[MODRESIDUAL_LENGTH-1:0]),
        .reduced (reduced),
        .mapped  (mapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            errorModulo <= '0;
            errReduced  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                errorModulo <= mapped;
                errReduced  <= reduced;
            end
        end
    end

endmodule

// File: tb/tb_error_mod_map.sv
// Scoreboard bench for error_mod_map: directed cases, streaming, reset and a full input sweep.
module tb_error_mod_map;
    import error_mod_map_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [8:0] errValue;
    logic       out_valid;
    logic [7:0] errorModulo;
    logic [7:0] errReduced;

    typedef struct {
        string      tag;
        logic [7:0] m;
        logic [7:0] r;
    } exp_t;

    exp_t       q[$];
    int         checks;
    int         errors;
    logic [7:0] last_m;
    logic [7:0] last_r;
    int         occ[256];

    error_mod_map #(
        .RESIDUAL_LENGTH   (9),
        .MODRESIDUAL_LENGTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .errValue   (errValue),
        .out_valid  (out_valid),
        .errorModulo(errorModulo),
        .errReduced (errReduced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural reference: add RANGE if negative, subtract RANGE if >= RANGE/2, then fold sign.
    function automatic void ref_model(input int x, output logic [7:0] m, output logic [7:0] r);
        int v;
        int mv;
        v = x;
        if (v < 0) v = v + int'(RANGE);
        if (v >= int'(RANGE) / 2) v = v - int'(RANGE);
        mv = (v >= 0) ? 2 * v : -2 * v - 1;
        r = v[7:0];
        m = mv[7:0];
    endfunction

    task automatic do_cycle(input int x, input logic v, input string tag);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        errValue = x[8:0];
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, int'(out_valid), int'(v));
        if (v) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL %s.queue: observed %0d entries expected 1", tag, q.size());
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".errorModulo"}, int'(errorModulo), int'(e.m));
                chk({e.tag, ".errReduced"}, int'(errReduced), int'(e.r));
                last_m = e.m;
                last_r = e.r;
            end
        end else begin
            chk({tag, ".hold_errorModulo"}, int'(errorModulo), int'(last_m));
            chk({tag, ".hold_errReduced"}, int'(errReduced), int'(last_r));
        end
    endtask

    task automatic drive_exp(input int x, input int m, input int r, input string tag);
        exp_t e;
        e.tag = tag;
        e.m   = m[7:0];
        e.r   = r[7:0];
        q.push_back(e);
        do_cycle(x, 1'b1, tag);
    endtask

    task automatic drive_model(input int x, input string tag);
        exp_t e;
        e.tag = tag;
        ref_model(x, e.m, e.r);
        q.push_back(e);
        do_cycle(x, 1'b1, tag);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        last_m   = '0;
        last_r   = '0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        errValue = 9'd5;
        foreach (occ[i]) occ[i] = 0;

        // Reset held with a valid sample presented.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.errorModulo", int'(errorModulo), 0);
        chk("rst.errReduced", int'(errReduced), 0);

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        do_cycle(0, 1'b0, "post_rst_idle");

        // Small values.
        drive_exp(0, 0, 0, "small0");
        drive_exp(5, 10, 5, "small5");
        drive_exp(-1, 1, -1, "small_m1");
        drive_exp(127, 254, 127, "small127");
        drive_exp(-128, 255, -128, "small_m128");

        // Wrap-around.
        drive_exp(200, 111, -56, "wrap200");
        drive_exp(-200, 112, 56, "wrap_m200");
        drive_exp(128, 255, -128, "wrap128");
        drive_exp(255, 1, -1, "wrap255");
        drive_exp(-255, 2, 1, "wrap_m255");

        // Streaming then idle hold.
        drive_exp(200, 111, -56, "stream0");
        drive_exp(-200, 112, 56, "stream1");
        drive_exp(0, 0, 0, "stream2");
        drive_exp(127, 254, 127, "hold_src");
        do_cycle(33, 1'b0, "idle0");
        do_cycle(-77, 1'b0, "idle1");

        // Out-of-range -RANGE pattern reduces by the same slice rule.
        drive_exp(-256, 0, 0, "minus_range");

        // Asynchronous reset mid-stream discards the in-flight sample.
        drive_exp(100, 200, 100, "pre_rst");
        @(negedge clk);
        in_valid = 1'b1;
        errValue = 9'd77;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", int'(out_valid), 0);
        chk("async_rst.errorModulo", int'(errorModulo), 0);
        chk("async_rst.errReduced", int'(errReduced), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        last_m   = '0;
        last_r   = '0;
        do_cycle(77, 1'b0, "after_async_rst");

        // Exhaustive sweep against the behavioural reference.
        for (int x = -255; x <= 255; x++) begin
            drive_model(x, "sweep");
            occ[errorModulo]++;
        end
        chk("sweep.occ0", occ[0], 1);
        for (int unsigned k = 1; k < 256; k++) begin
            chk($sformatf("sweep.occ%0d", k), occ[k], 2);
        end

        do_cycle(0, 1'b0, "final_idle");
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
